log_scheduler: RTL and testbench

Sequencing controller between the SPI ADC controller and the I2C EEPROM controller in the data logger. Generates the periodic sample strobe, triggers one ADC conversion per strobe, and packs results into 512-bit pages (32 × 16-bit words) in a ping-pong page cache. Hands each full page to the EEPROM writer with a req/ack handshake and increments the page address. Stops logging when the EEPROM is full.

---
 rtl/log_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_log_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_scheduler.sv
// log_scheduler
//
// Sequencing controller between the SPI ADC controller and the I2C EEPROM
// controller of the data logger. A free-running divider produces the sample
// strobe. Each strobe launches one ADC conversion. Results are packed into
// 32-word (512-bit) pages held in a two-entry ping-pong page cache. Each full
// page is offered to the EEPROM writer through a req/ack handshake. Logging
// halts for good once the last EEPROM page has been acknowledged.
//
// Ports
//   CLK_50MHz   in   system clock, rising edge
//   RESET       in   synchronous, active-high reset
//   enable      in   logging enable (level)
//   adc_start   out  one-cycle conversion request
//   adc_done    in   one-cycle conversion-complete pulse
//   adc_data    in   conversion result, valid while adc_done is high
//   page_req    out  a full page is presented on page_data/page_addr
//   page_ack    in   one-cycle pulse, the EEPROM controller took the page
//   page_data   out  page contents, word i at bits [16i+15:16i]
//   page_addr   out  EEPROM page index of page_data
//   drop_count  out  saturating count of lost samples
//   mem_full    out  every EEPROM page has been written, logging halted

module log_scheduler #(
    parameter int SAMPLE_DIV = 50000,
    parameter int ADC_BITS   = 12,
    parameter int PAGES      = 512,
    localparam int ADDR_W    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                CLK_50MHz,
    input  logic                RESET,
    input  logic                enable,
    output logic                adc_start,
    input  logic                adc_done,
    input  logic [ADC_BITS-1:0] adc_data,
    output logic                page_req,
    input  logic                page_ack,
    output logic [511:0]        page_data,
    output logic [ADDR_W-1:0]   page_addr,
    output logic [7:0]          drop_count,
    output logic                mem_full
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    typedef enum logic { S_IDLE, S_CONV } samp_state_t;
    typedef enum logic { W_IDLE, W_REQ  } wr_state_t;

    // Zero-extend an ADC result to a 16-bit page word.
    function automatic logic [15:0] word_ext(input logic [ADC_BITS-1:0] d);
        logic [15:0] w;
        w = '0;
        w[ADC_BITS-1:0] = d;
        return w;
    endfunction

    // Saturating add of up to two lost samples per cycle.
    function automatic logic [7:0] drop_sat_add(input logic [7:0] cnt,
                                                input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Sample strobe divider
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] strobe_cnt;
    logic             run_en;
    logic             strobe;

    assign run_en = enable && !mem_full;
    assign strobe = run_en && (strobe_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge CLK_50MHz) begin
        if (RESET || !run_en || strobe) begin
            strobe_cnt <= '0;
        end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample FSM
    // ------------------------------------------------------------------
    samp_state_t s_state, s_next;
    logic        adc_start_next;
    logic        accept;       // conversion result arrives for us
    logic        strobe_lost;  // strobe while a conversion is in flight

    always_comb begin
        s_next         = s_state;
        adc_start_next = 1'b0;
        accept         = 1'b0;
        strobe_lost    = 1'b0;
        case (s_state)
            S_IDLE: begin
                if (strobe) begin
                    adc_start_next = 1'b1;
                    s_next         = S_CONV;
                end
            end
            S_CONV: begin
                // Enable may drop here; the in-flight result is still taken.
                strobe_lost = strobe;
                if (adc_done) begin
                    accept = 1'b1;
                    s_next = S_IDLE;
                end
            end
            default: s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            s_state   <= S_IDLE;
            adc_start <= 1'b0;
        end else begin
            s_state   <= s_next;
            adc_start <= adc_start_next;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong page cache
    // ------------------------------------------------------------------
    logic [511:0] page_buf [2];
    logic [1:0]   buf_full;
    logic         fill_ptr;
    logic         rd_ptr;
    logic [4:0]   widx;
    logic         store;
    logic         discard;
    logic         last_word;
    logic         ack_take;

    // The fill pointer only ever lands on a full buffer when both are full.
    assign discard   = accept && buf_full[fill_ptr];
    assign store     = accept && !buf_full[fill_ptr];
    assign last_word = store && (widx == 5'd31);

    // Buffer contents carry no reset; page_data is gated while idle.
    always_ff @(posedge CLK_50MHz) begin
        if (store) begin
            page_buf[fill_ptr][{widx, 4'b0000} +: 16] <= word_ext(adc_data);
        end
    end

    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            buf_full <= 2'b00;
            fill_ptr <= 1'b0;
            rd_ptr   <= 1'b0;
            widx     <= '0;
        end else begin
            if (store) begin
                widx <= widx + 1'b1;
            end
            if (last_word) begin
                buf_full[fill_ptr] <= 1'b1;
                fill_ptr           <= ~fill_ptr;
            end
            // A completing write and an ack always target different buffers.
            if (ack_take) begin
                buf_full[rd_ptr] <= 1'b0;
                rd_ptr           <= ~rd_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    wr_state_t w_state, w_next;
    logic      page_pending;

    // Buffers complete in the same order they are read, so rd_ptr is always
    // the oldest. A word-31 write into it this cycle counts as full already,
    // so the request rises on the following cycle.
    assign page_pending = buf_full[rd_ptr] || (last_word && (fill_ptr == rd_ptr));
    assign ack_take     = (w_state == W_REQ) && page_ack;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (page_pending && !mem_full) begin
                    w_next = W_REQ;
                end
            end
            W_REQ: begin
                // Returning through W_IDLE guarantees a low cycle on page_req.
                if (page_ack) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    assign page_req  = (w_state == W_REQ);
    assign page_data = page_req ? page_buf[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Page address, end of memory, drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            page_addr  <= '0;
            mem_full   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (ack_take) begin
                // The address parks on the last page instead of wrapping.
                if (page_addr == ADDR_W'(PAGES - 1)) begin
                    mem_full <= 1'b1;
                end else begin
                    page_addr <= page_addr + 1'b1;
                end
            end
            drop_count <= drop_sat_add(drop_count,
                                       {1'b0, strobe_lost} + {1'b0, discard});
        end
    end

endmodule

// File: tb/tb_log_scheduler.sv
module tb_log_scheduler;

    localparam int SAMPLE_DIV = 8;
    localparam int ADC_BITS   = 12;
    localparam int PAGES      = 4;
    localparam int AW         = 2;

    logic                clk = 1'b0;
    logic                RESET;
    logic                enable;
    logic                adc_start;
    logic                adc_done;
    logic [ADC_BITS-1:0] adc_data;
    logic                page_req;
    logic                page_ack;
    logic [511:0]        page_data;
    logic [AW-1:0]       page_addr;
    logic [7:0]          drop_count;
    logic                mem_full;

    always #5 clk = ~clk;

    log_scheduler #(.SAMPLE_DIV(SAMPLE_DIV), .ADC_BITS(ADC_BITS), .PAGES(PAGES)) dut (
        .CLK_50MHz  (clk),
        .RESET      (RESET),
        .enable     (enable),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .page_req   (page_req),
        .page_ack   (page_ack),
        .page_data  (page_data),
        .page_addr  (page_addr),
        .drop_count (drop_count),
        .mem_full   (mem_full)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int           m_phase;      // enabled cycles since the last strobe
    bit           m_busy;       // a conversion is outstanding
    int           m_drop;
    bit           m_mf;
    int           m_addr;
    bit           m_start;
    bit           m_ack_edge;
    logic [511:0] m_cur;
    int           m_widx;
    logic [511:0] m_full_q[$];
    int           acked_pages = 0;
    int           n_done = 0;

    task automatic model_reset();
        m_phase = 0; m_busy = 0; m_drop = 0; m_mf = 0; m_addr = 0;
        m_start = 0; m_ack_edge = 0; m_cur = '0; m_widx = 0;
        m_full_q.delete();
    endtask

    task automatic lose_one();
        if (m_drop < 255) m_drop++;
    endtask

    // Predict the effect of the coming rising edge from the inputs now applied.
    task automatic model_edge();
        bit strobe, started, ok_done;
        strobe = 0; started = 0;
        if (RESET) begin
            model_reset();
            return;
        end
        if (adc_done) n_done++;
        if (enable && !m_mf) begin
            if (m_phase == SAMPLE_DIV - 1) begin
                strobe  = 1;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end else begin
            m_phase = 0;
        end
        m_start = 0;
        if (strobe) begin
            if (m_busy) lose_one();
            else begin
                m_start = 1;
                started = 1;
            end
        end
        ok_done = adc_done && m_busy;
        if (ok_done) begin
            if (m_full_q.size() == 2) lose_one();
            else begin
                m_cur[m_widx*16 +: 16] = 16'(adc_data);
                m_widx++;
                if (m_widx == 32) begin
                    m_full_q.push_back(m_cur);
                    m_cur  = '0;
                    m_widx = 0;
                end
            end
        end
        m_busy = (m_busy && !ok_done) || started;
        m_ack_edge = 0;
        if (page_ack && m_full_q.size() > 0 && !m_mf) begin
            void'(m_full_q.pop_front());
            acked_pages++;
            m_ack_edge = 1;
            if (m_addr == PAGES - 1) m_mf = 1;
            else m_addr++;
        end
    endtask

    // ---------------- bench-side ADC and EEPROM models ----------------
    int lat_min = 3, lat_max = 3;
    int ack_dly = 4;
    bit ack_en = 1;
    bit data_rand = 0;
    bit word_chk = 0;
    int data_k = 0;
    int cd = 0;
    int acnt = 0;

    task automatic step();
        model_edge();
        @(negedge clk);
        check("adc_start", adc_start, m_start);
        check("drop_count", drop_count, m_drop);
        check("mem_full", mem_full, m_mf);
        check("page_addr", page_addr, m_addr);
        if (m_ack_edge) check("req_gap", page_req, 1'b0);
        if (m_full_q.size() == 0) check("req_without_page", page_req, 1'b0);
        adc_done = 0;
        page_ack = 0;
        if (adc_start) cd = $urandom_range(lat_max, lat_min);
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                adc_done = 1;
                adc_data = data_rand ? ADC_BITS'($urandom) : ADC_BITS'(data_k);
                data_k++;
            end
        end
        if (page_req && ack_en) begin
            acnt++;
            if (acnt > ack_dly) begin
                acnt = 0;
                page_ack = 1;
                check("page_data", page_data, (m_full_q.size() > 0) ? m_full_q[0] : '0);
                if (word_chk) begin
                    check("page_word0", page_data[15:0], 16'(m_addr * 32));
                    check("page_word31", page_data[511:496], 16'(m_addr * 32 + 31));
                end
            end
        end else begin
            acnt = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adc_start"}, adc_start, 1'b0);
        check({tag, "_page_req"}, page_req, 1'b0);
        check({tag, "_page_data"}, page_data, '0);
        check({tag, "_page_addr"}, page_addr, '0);
        check({tag, "_drop"}, drop_count, '0);
        check({tag, "_mem_full"}, mem_full, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        enable = 0;
        RESET  = 1;
        step();
        RESET  = 0;
        cd     = 0;
        adc_done = 0;
        acnt   = 0;
        check_reset_outputs(tag);
    endtask

    task automatic run_until_acks(input int n, input int budget, input string tag);
        int start, c;
        start = acked_pages;
        c = 0;
        while (acked_pages - start < n && c < budget) begin
            step();
            c++;
        end
        check(tag, acked_pages - start, n);
    endtask

    task automatic run_until_full(input int budget, input string tag);
        int c;
        c = 0;
        while (!m_mf && c < budget) begin
            step();
            c++;
        end
        check(tag, mem_full, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts, d0;
        RESET = 1; enable = 0; adc_done = 0; adc_data = '0; page_ack = 0;
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        // Fixed ADC latency, prompt acks, data = sample index; run to end of memory.
        lat_min = 3; lat_max = 3; ack_dly = 4; ack_en = 1;
        data_rand = 0; word_chk = 1; data_k = 0;
        enable = 1;
        run_until_acks(2, 1500, "basic_two_pages");
        check("basic_no_drops", drop_count, 8'd0);
        run_until_full(1500, "mem_full_reached");
        check("full_page_addr", page_addr, 2'd3);
        starts = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (adc_start) starts++;
        end
        check("no_start_when_full", starts, 0);
        word_chk = 0;
        do_reset("rst_full");

        // Random latency, random ack delay, random data, enable toggling.
        lat_min = 1; lat_max = 12; ack_dly = $urandom_range(6, 0);
        data_rand = 1; enable = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199, 0) == 0) enable = ~enable;
            step();
        end
        enable = 1;
        run_until_full(6000, "random_mem_full");
        do_reset("rst_rand");

        // Acks withheld: both buffers fill, further samples are discarded.
        lat_min = 3; lat_max = 3; ack_en = 0; enable = 1;
        d0 = n_done;
        for (int i = 0; i < 660; i++) step();
        check("withheld_drops", drop_count, 8'(n_done - d0 - 64));
        ack_en = 1;
        run_until_acks(2, 1500, "withheld_resume");
        do_reset("rst_withheld");

        // Every other strobe lost; the drop counter must saturate.
        lat_min = 10; lat_max = 10; ack_en = 0; enable = 1;
        for (int i = 0; i < 4500; i++) step();
        check("drop_saturated", drop_count, 8'd255);

        // Reset while page_req is high and a conversion is in flight.
        for (int i = 0; i < 40 && cd == 0; i++) step();
        check("pre_reset_req", page_req, 1'b1);
        check("pre_reset_inflight", cd > 0, 1'b1);
        enable = 0;
        RESET  = 1;
        step();
        RESET  = 0;
        check_reset_outputs("rst_mid");
        page_ack = 1;
        for (int i = 0; i < 20; i++) step();
        check_reset_outputs("stray");
        lat_min = 3; lat_max = 3; ack_en = 1; enable = 1;
        run_until_acks(1, 1500, "after_reset_page");
        check("after_reset_addr", page_addr, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
